wb_stage: RTL and testbench

//   Writeback stage directly upstream of the register file. Accepts completed

---
 rtl/wb_stage.sv | 111 +++++++++++
 tb/tb_wb_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file; retires ALU results and
// waits for multi-cycle load responses, extracting and extending load data.
module wb_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [2:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic             flush,
    input  logic             mem_rsp_valid,
    input  logic [63:0]      mem_rsp_data,
    output logic             reg_write,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  write_data,
    output logic             wb_valid,
    output logic             ld_pend,
    output logic [4:0]       ld_pend_rd,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_count
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic accept;
    logic [4:0] ld_rd;
    logic [2:0] ld_f3, ld_off;
    logic ld_regw;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] w;
    logic [XLEN-1:0] ld_data;

    assign in_ready   = state == IDLE;
    assign accept     = in_valid & in_ready & ~flush;
    assign ld_pend    = state == WAIT;
    assign ld_pend_rd = ld_pend ? ld_rd : 5'd0;

    // Lane selects: low offset bits below the access size are ignored.
    assign b = mem_rsp_data[{ld_off, 3'b000} +: 8];
    assign h = mem_rsp_data[{ld_off[2:1], 4'b0000} +: 16];
    assign w = mem_rsp_data[{ld_off[2], 5'b00000} +: 32];

    always_comb begin
        ld_data = '0;
        case (ld_f3)
            3'b000: ld_data = {{(XLEN-8){b[7]}}, b};
            3'b001: ld_data = {{(XLEN-16){h[15]}}, h};
            3'b010: ld_data = {{(XLEN-32){w[31]}}, w};
            3'b011: ld_data = mem_rsp_data;
            3'b100: ld_data = {{(XLEN-8){1'b0}}, b};
            3'b101: ld_data = {{(XLEN-16){1'b0}}, h};
            3'b110: ld_data = {{(XLEN-32){1'b0}}, w};
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && accept && in_is_load) state_nxt = WAIT;
        if (state == WAIT && mem_rsp_valid) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write    <= 1'b0;
            rd           <= '0;
            write_data   <= '0;
            wb_valid     <= 1'b0;
            load_err     <= 1'b0;
            ld_rd        <= '0;
            ld_f3        <= '0;
            ld_off       <= '0;
            ld_regw      <= 1'b0;
            retire_count <= '0;
        end else begin
            wb_valid  <= 1'b0;
            reg_write <= 1'b0;
            load_err  <= 1'b0;
            if (accept && !in_is_load) begin
                wb_valid   <= 1'b1;
                reg_write  <= in_reg_write && in_rd != 5'd0;
                rd         <= in_rd;
                write_data <= in_result;
            end else if (state == WAIT && mem_rsp_valid) begin
                wb_valid   <= 1'b1;
                reg_write  <= ld_regw && ld_rd != 5'd0;
                rd         <= ld_rd;
                write_data <= ld_data;
                load_err   <= ld_f3 == 3'b111;
            end
            if (accept && in_is_load) begin
                ld_rd   <= in_rd;
                ld_f3   <= in_funct3;
                ld_off  <= in_addr_lo;
                ld_regw <= in_reg_write;
            end
            if (wb_valid) retire_count <= retire_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven directed checks of wb_stage plus hand-written
// multi-cycle sequences (back-to-back, late response, flush, reset in WAIT).
module tb_wb_stage;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid, in_ready, in_reg_write, in_is_load, flush, mem_rsp_valid;
    logic [4:0] in_rd, rd, ld_pend_rd;
    logic [2:0] in_funct3, in_addr_lo;
    logic [63:0] in_result, mem_rsp_data, write_data, retire_count;
    logic reg_write, wb_valid, ld_pend, load_err;
    int errors = 0, checks = 0;
    logic [63:0] exp_cnt = 0;

    typedef struct {
        logic        regw;
        logic [4:0]  rd;
        logic        ld;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] val;
        logic [63:0] exp;
        logic        exp_regw;
        logic        exp_err;
    } vec_t;
    vec_t v[13];

    wb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_result(in_result),
        .flush(flush), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .reg_write(reg_write), .rd(rd), .write_data(write_data), .wb_valid(wb_valid),
        .ld_pend(ld_pend), .ld_pend_rd(ld_pend_rd), .load_err(load_err),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = '{1'b1, 5'd5, 1'b0, 3'd0, 3'd0, 64'h1234, 64'h1234, 1'b1, 1'b0};
        v[1]  = '{1'b1, 5'd0, 1'b0, 3'd0, 3'd0, 64'hdead, 64'hdead, 1'b0, 1'b0};
        v[2]  = '{1'b0, 5'd7, 1'b0, 3'd0, 3'd0, 64'h55aa, 64'h55aa, 1'b0, 1'b0};
        v[3]  = '{1'b1, 5'd3, 1'b1, 3'd0, 3'd3, 64'h0000_0000_8000_0000, 64'hffff_ffff_ffff_ff80, 1'b1, 1'b0};
        v[4]  = '{1'b1, 5'd3, 1'b1, 3'd4, 3'd3, 64'h0000_0000_8000_0000, 64'h80, 1'b1, 1'b0};
        v[5]  = '{1'b1, 5'd4, 1'b1, 3'd1, 3'd3, 64'h0000_0000_9abc_0000, 64'hffff_ffff_ffff_9abc, 1'b1, 1'b0};
        v[6]  = '{1'b1, 5'd6, 1'b1, 3'd5, 3'd6, 64'hf00d_0000_0000_0000, 64'hf00d, 1'b1, 1'b0};
        v[7]  = '{1'b1, 5'd8, 1'b1, 3'd2, 3'd4, 64'h8000_0000_0000_0000, 64'hffff_ffff_8000_0000, 1'b1, 1'b0};
        v[8]  = '{1'b1, 5'd9, 1'b1, 3'd6, 3'd5, 64'h8765_4321_0000_0000, 64'h8765_4321, 1'b1, 1'b0};
        v[9]  = '{1'b1, 5'd10, 1'b1, 3'd3, 3'd5, 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef, 1'b1, 1'b0};
        v[10] = '{1'b1, 5'd11, 1'b1, 3'd2, 3'd0, 64'h0000_0000_7fff_ffff, 64'h7fff_ffff, 1'b1, 1'b0};
        v[11] = '{1'b0, 5'd12, 1'b1, 3'd7, 3'd2, 64'hffff_ffff_ffff_ffff, 64'h0, 1'b0, 1'b1};
        v[12] = '{1'b1, 5'd0, 1'b1, 3'd0, 3'd7, 64'h7f00_0000_0000_0000, 64'h7f, 1'b0, 1'b0};

        in_valid = 0; in_reg_write = 0; in_rd = 0; in_is_load = 0; in_funct3 = 0;
        in_addr_lo = 0; in_result = 0; flush = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        tick(); tick();
        chk("rst.in_ready", in_ready, 1);
        chk("rst.reg_write", reg_write, 0);
        chk("rst.rd", rd, 0);
        chk("rst.write_data", write_data, 0);
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.ld_pend", ld_pend, 0);
        chk("rst.ld_pend_rd", ld_pend_rd, 0);
        chk("rst.load_err", load_err, 0);
        chk("rst.count", retire_count, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 13; i++) begin
            in_valid = 1; in_reg_write = v[i].regw; in_rd = v[i].rd; in_is_load = v[i].ld;
            in_funct3 = v[i].f3; in_addr_lo = v[i].off; in_result = v[i].ld ? 64'h0 : v[i].val;
            tick();
            in_valid = 0;
            if (v[i].ld) begin
                chk($sformatf("v%0d.ld_pend", i), ld_pend, 1);
                chk($sformatf("v%0d.ld_pend_rd", i), ld_pend_rd, v[i].rd);
                chk($sformatf("v%0d.in_ready", i), in_ready, 0);
                chk($sformatf("v%0d.early_wb", i), wb_valid, 0);
                mem_rsp_data = v[i].val; mem_rsp_valid = 1;
                tick();
                mem_rsp_valid = 0;
                chk($sformatf("v%0d.ld_pend_clr", i), ld_pend, 0);
                chk($sformatf("v%0d.in_ready_back", i), in_ready, 1);
            end
            chk($sformatf("v%0d.wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d.reg_write", i), reg_write, v[i].exp_regw);
            chk($sformatf("v%0d.rd", i), rd, v[i].rd);
            chk($sformatf("v%0d.write_data", i), write_data, v[i].exp);
            chk($sformatf("v%0d.load_err", i), load_err, v[i].exp_err);
            exp_cnt++;
        end
        in_is_load = 0;
        tick();
        chk("table.count", retire_count, exp_cnt);

        // Stray response while idle is ignored
        mem_rsp_valid = 1; mem_rsp_data = 64'h1;
        tick();
        mem_rsp_valid = 0;
        chk("stray.wb_valid", wb_valid, 0);
        chk("stray.ld_pend", ld_pend, 0);

        // Four back-to-back ALU ops
        in_valid = 1; in_reg_write = 1;
        for (int k = 0; k < 4; k++) begin
            in_rd = 5'(k + 1); in_result = 64'(k) * 64'h11 + 64'h100;
            chk($sformatf("b2b%0d.in_ready", k), in_ready, 1);
            tick();
            chk($sformatf("b2b%0d.wb_valid", k), wb_valid, 1);
            chk($sformatf("b2b%0d.write_data", k), write_data, 64'(k) * 64'h11 + 64'h100);
            chk($sformatf("b2b%0d.rd", k), rd, 64'(k + 1));
        end
        in_valid = 0;
        tick();
        exp_cnt += 4;
        chk("b2b.wb_end", wb_valid, 0);
        chk("b2b.count", retire_count, exp_cnt);

        // Flushed ALU op and flushed load do not transfer
        in_valid = 1; flush = 1; in_is_load = 0; in_rd = 5'd2; in_result = 64'h77;
        tick();
        chk("flush.alu_wb", wb_valid, 0);
        in_is_load = 1;
        tick();
        chk("flush.ld_pend", ld_pend, 0);
        in_valid = 0; flush = 0; in_is_load = 0;
        tick();
        chk("flush.count", retire_count, exp_cnt);

        // LW offset 4, response 3 cycles late; same-cycle response ignored;
        // flush while waiting does not cancel the outstanding load
        in_valid = 1; in_is_load = 1; in_funct3 = 3'd2; in_addr_lo = 3'd4; in_rd = 5'd20;
        in_reg_write = 1; mem_rsp_valid = 1; mem_rsp_data = 64'h1111_1111_1111_1111;
        tick();
        in_valid = 0; in_is_load = 0; mem_rsp_valid = 0; flush = 1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("late%0d.ld_pend", k), ld_pend, 1);
            chk($sformatf("late%0d.in_ready", k), in_ready, 0);
            chk($sformatf("late%0d.wb_valid", k), wb_valid, 0);
            if (k == 2) begin
                mem_rsp_valid = 1; mem_rsp_data = 64'h8000_0000_0000_0000;
            end
            tick();
        end
        mem_rsp_valid = 0; flush = 0;
        chk("late.wb_valid", wb_valid, 1);
        chk("late.write_data", write_data, 64'hffff_ffff_8000_0000);
        chk("late.rd", rd, 20);
        chk("late.ld_pend", ld_pend, 0);
        chk("late.in_ready", in_ready, 1);
        exp_cnt++;
        tick();
        chk("late.count", retire_count, exp_cnt);

        // Reset during WAIT: late response ignored
        in_valid = 1; in_is_load = 1; in_funct3 = 3'd3; in_rd = 5'd9;
        tick();
        in_valid = 0; in_is_load = 0;
        chk("rwait.ld_pend", ld_pend, 1);
        #2 reset = 1;
        #1;
        chk("rwait.in_ready_async", in_ready, 1);
        chk("rwait.count_async", retire_count, 0);
        tick();
        reset = 0;
        mem_rsp_valid = 1; mem_rsp_data = 64'hffff;
        tick();
        mem_rsp_valid = 0;
        chk("rwait.wb_valid", wb_valid, 0);
        chk("rwait.reg_write", reg_write, 0);
        chk("rwait.in_ready", in_ready, 1);
        tick();
        chk("rwait.count", retire_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
